audiodac_sample_mon: RTL and testbench
======================================

Name: audiodac_sample_mon

Overview:
- Sample-consumer test monitor: the reader side of the 16-bit UINT sample source interface (`data` plus one-cycle read strobe) used by the sine generator and FIFO.
- Issues read strobes at a programmable rate and captures each returned sample.
- Accumulates min/max, rising mid-scale crossing count and crossing period for built-in self-test of the sample path.
- Sits beside the modulator input in test mode. All outputs are static registers readable by the test controller.

Parameters:
DIV_W, 8, width of the read-rate divider input.

Ports:
clk_i  input  1  system clock.
rst_n_i  input  1  reset, asynchronous, active-low.
data_i  input  16  sample from source, UINT with mid-scale 0x8000; valid in the cycle data_rd_o=1.
data_rd_o  output  1  one-cycle read strobe to source.
mon_en_i  input  1  enables strobe generation and capture.
mon_div_i  input  DIV_W  strobe every (mon_div_i+1) clocks.
mon_clr_i  input  1  synchronous clear of statistics.
mon_sample_o  output  16  last captured sample.
mon_valid_o  output  1  one-cycle pulse, cycle after capture.
mon_min_o  output  16  minimum captured sample since clear.
mon_max_o  output  16  maximum captured sample since clear.
mon_cross_o  output  8  rising mid-scale crossing count, saturates at 255.
mon_period_o  output  16  samples between the last two rising crossings, saturates at 0xFFFF.

Behaviour:
- Clock, reset and registers:
  - One clock domain, clk_i.
  - Reset is asynchronous, active-low, on rst_n_i. All state is async-reset.
  - Reset values: data_rd_o=0, mon_valid_o=0, mon_sample_o=0, mon_min_o=0xFFFF, mon_max_o=0, mon_cross_o=0, mon_period_o=0.
  - Reset values of internal state: div counter=0, first-flag=1, prev-below flag=0, crossing-seen flag=0, sample counter=0.
- Rate counter:
  - While mon_en_i=1, the down-counter asserts data_rd_o for one cycle when it equals 0, then reloads mon_div_i.
  - mon_div_i=0 gives data_rd_o=1 every cycle.
  - First strobe occurs in the first cycle after mon_en_i rises.
  - A mon_div_i change takes effect at the next reload.
  - mon_en_i=0: data_rd_o=0 combinationally gated, counter forced to 0, statistics held.
- Capture:
  - On the clock edge where data_rd_o=1, data_i is registered into mon_sample_o.
  - mon_valid_o=1 in the following cycle.
  - Total latency from strobe to visible output is 1 cycle.
- Statistics, updated on each capture:
  - First capture after reset/clear: min=max=sample, no crossing evaluated, first-flag cleared, prev-below = (sample < 0x8000).
  - Later captures:
    - min/max update with unsigned compare.
    - Rising crossing = prev-below=1 AND sample >= 0x8000.
  - Sample counter counts captures since the last crossing, saturating at 0xFFFF.
  - On a crossing:
    - mon_cross_o increments (saturating).
    - If crossing-seen=1, mon_period_o <= sample counter + 1, saturated at 0xFFFF.
    - crossing-seen <= 1; counter <= 0.
  - prev-below is updated every capture.
- Clear:
  - mon_clr_i=1 restores the reset values of all statistics and flags. mon_sample_o and the rate counter are unaffected.
  - Clear has priority over a same-cycle capture. That sample is still written to mon_sample_o and mon_valid_o pulses, but statistics remain cleared and the first-flag stays set.
- Reset mid-operation: immediate return to reset values, no strobe issued while rst_n_i=0.

Test Plan:
1. Assert rst_n_i=0 mid-cycle with mon_en_i=1 and div=0 -> all outputs at reset values immediately, no strobe until release; after release, data_rd_o rises the first cycle.
2. div=3, en=1 for 40 cycles -> data_rd_o high exactly 1 of every 4 cycles (10 pulses); mon_valid_o trails each strobe by 1 cycle; changing to div=0 mid-count takes effect after the current reload.
3. Bench source is a 64-entry 90% sine table starting at 0x8000, advancing one entry per strobe, div=0, 130 captures -> min=0x0CCD, max=0xF333, mon_cross_o=2 (samples 64 and 128), mon_period_o=64.
4. Source alternates 0x7000/0x9000 -> crossing every 2 samples, mon_period_o=2; after 300 crossings mon_cross_o=255 (saturated).
5. Source held at 0x7FFF for 70000 captures, then 0x8000 following a prior crossing -> mon_period_o=0xFFFF (saturated), mon_cross_o increments by 1.
6. mon_clr_i pulsed in the same cycle as a capture of 0x1234 -> mon_sample_o=0x1234, mon_valid_o pulses, min=0xFFFF, max=0, cross=0, period=0; next capture 0x5555 sets min=max=0x5555.

Source files
------------

// File: rtl/audiodac_sample_mon.sv
// -----------------------------------------------------------------------------
// audiodac_sample_mon
//
// Test-mode consumer of the 16-bit UINT sample source interface (data plus a
// one-cycle read strobe). It pulls samples at a programmable rate, captures
// each one, and keeps simple statistics for self-test of the sample path:
// minimum, maximum, rising mid-scale crossing count and the number of samples
// between the last two rising crossings.
//
// Ports
//   clk_i         system clock
//   rst_n_i       asynchronous active-low reset
//   data_i        sample from source (UINT, mid-scale 0x8000), valid while
//                 data_rd_o=1
//   data_rd_o     one-cycle read strobe to the source
//   mon_en_i      enables strobe generation and capture
//   mon_div_i     strobe period minus one, in clocks
//   mon_clr_i     synchronous clear of statistics
//   mon_sample_o  last captured sample
//   mon_valid_o   one-cycle pulse in the cycle after a capture
//   mon_min_o     minimum captured sample since clear
//   mon_max_o     maximum captured sample since clear
//   mon_cross_o   rising mid-scale crossing count, saturates at 255
//   mon_period_o  samples between the last two rising crossings, saturating
// -----------------------------------------------------------------------------
module audiodac_sample_mon #(
   parameter int DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [15:0]      data_i,
   output logic             data_rd_o,
   input  logic             mon_en_i,
   input  logic [DIV_W-1:0] mon_div_i,
   input  logic             mon_clr_i,
   output logic [15:0]      mon_sample_o,
   output logic             mon_valid_o,
   output logic [15:0]      mon_min_o,
   output logic [15:0]      mon_max_o,
   output logic [7:0]       mon_cross_o,
   output logic [15:0]      mon_period_o
);

   localparam logic [15:0] MID_SCALE = 16'h8000;

   function automatic logic [15:0] sat_inc16(input logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] x);
      return (x == 8'hFF) ? x : x + 8'd1;
   endfunction

   logic [DIV_W-1:0] div_cnt;
   logic             first_flag;
   logic             prev_below;
   logic             cross_seen;
   logic [15:0]      smp_cnt;
   logic             is_below;
   logic             is_cross;

   // Gated by rst_n_i as well so no strobe can reach the source while the
   // block is held in reset (the idle counter value 0 would otherwise fire).
   assign data_rd_o = rst_n_i & mon_en_i & (div_cnt == '0);

   // Rate counter: a new mon_div_i value is only picked up at reload.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         div_cnt <= '0;
      end else if (!mon_en_i) begin
         div_cnt <= '0;
      end else if (div_cnt == '0) begin
         div_cnt <= mon_div_i;
      end else begin
         div_cnt <= div_cnt - 1'b1;
      end
   end

   // Capture stage: sample register is independent of the statistics clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mon_sample_o <= '0;
         mon_valid_o  <= 1'b0;
      end else begin
         mon_valid_o <= data_rd_o;
         if (data_rd_o) begin
            mon_sample_o <= data_i;
         end
      end
   end

   always_comb begin
      is_below = (data_i < MID_SCALE);
      is_cross = !first_flag && prev_below && !is_below;
   end

   // Statistics stage: clear wins over a same-cycle capture.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mon_min_o    <= 16'hFFFF;
         mon_max_o    <= '0;
         mon_cross_o  <= '0;
         mon_period_o <= '0;
         first_flag   <= 1'b1;
         prev_below   <= 1'b0;
         cross_seen   <= 1'b0;
         smp_cnt      <= '0;
      end else if (mon_clr_i) begin
         mon_min_o    <= 16'hFFFF;
         mon_max_o    <= '0;
         mon_cross_o  <= '0;
         mon_period_o <= '0;
         first_flag   <= 1'b1;
         prev_below   <= 1'b0;
         cross_seen   <= 1'b0;
         smp_cnt      <= '0;
      end else if (data_rd_o) begin
         prev_below <= is_below;
         if (first_flag) begin
            mon_min_o  <= data_i;
            mon_max_o  <= data_i;
            first_flag <= 1'b0;
            smp_cnt    <= sat_inc16(smp_cnt);
         end else begin
            if (data_i < mon_min_o) mon_min_o <= data_i;
            if (data_i > mon_max_o) mon_max_o <= data_i;
            if (is_cross) begin
               mon_cross_o <= sat_inc8(mon_cross_o);
               // Period only becomes meaningful once a previous crossing exists.
               if (cross_seen) mon_period_o <= sat_inc16(smp_cnt);
               cross_seen <= 1'b1;
               smp_cnt    <= '0;
            end else begin
               smp_cnt <= sat_inc16(smp_cnt);
            end
         end
      end
   end

endmodule

// File: tb/tb_audiodac_sample_mon.sv
`timescale 1ns/1ps
module tb_audiodac_sample_mon;

   localparam int DIV_W = 8;

   logic             clk_i = 1'b0;
   logic             rst_n_i;
   logic [15:0]      data_i;
   logic             data_rd_o;
   logic             mon_en_i;
   logic [DIV_W-1:0] mon_div_i;
   logic             mon_clr_i;
   logic [15:0]      mon_sample_o;
   logic             mon_valid_o;
   logic [15:0]      mon_min_o;
   logic [15:0]      mon_max_o;
   logic [7:0]       mon_cross_o;
   logic [15:0]      mon_period_o;

   int total = 0;
   int bad   = 0;

   logic [15:0] mq[$];      // captured samples since last clear
   logic [15:0] sine_tab[64];

   typedef struct {
      logic [15:0] d;
      logic        clr;
      logic [15:0] e_min;
      logic [15:0] e_max;
      logic [7:0]  e_cross;
      logic [15:0] e_per;
   } vec_t;

   audiodac_sample_mon #(.DIV_W(DIV_W)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .data_i       (data_i),
      .data_rd_o    (data_rd_o),
      .mon_en_i     (mon_en_i),
      .mon_div_i    (mon_div_i),
      .mon_clr_i    (mon_clr_i),
      .mon_sample_o (mon_sample_o),
      .mon_valid_o  (mon_valid_o),
      .mon_min_o    (mon_min_o),
      .mon_max_o    (mon_max_o),
      .mon_cross_o  (mon_cross_o),
      .mon_period_o (mon_period_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference statistics computed directly from the list of captures.
   task automatic model_exp(output logic [15:0] emin, output logic [15:0] emax,
                            output logic [7:0] ecross, output logic [15:0] eper);
      int n = 0;
      int last = -1;
      int prev = -1;
      emin = 16'hFFFF;
      emax = 16'h0000;
      foreach (mq[k]) begin
         if (mq[k] < emin) emin = mq[k];
         if (mq[k] > emax) emax = mq[k];
         if (k > 0 && mq[k-1] < 16'h8000 && mq[k] >= 16'h8000) begin
            n++;
            prev = last;
            last = k;
         end
      end
      ecross = (n > 255) ? 8'hFF : 8'(n);
      if (prev < 0) eper = 16'h0000;
      else if (last - prev > 65535) eper = 16'hFFFF;
      else eper = 16'(last - prev);
   endtask

   task automatic chk_model(input string tag);
      logic [15:0] emin, emax, eper;
      logic [7:0]  ecross;
      model_exp(emin, emax, ecross, eper);
      chk({tag, "_min"},    32'(mon_min_o),    32'(emin));
      chk({tag, "_max"},    32'(mon_max_o),    32'(emax));
      chk({tag, "_cross"},  32'(mon_cross_o),  32'(ecross));
      chk({tag, "_period"}, 32'(mon_period_o), 32'(eper));
   endtask

   // One capture at div=0, en=1. Called and returns at posedge+1.
   task automatic cap(input logic [15:0] d, input logic clr, input bit do_chk);
      data_i    = d;
      mon_clr_i = clr;
      @(negedge clk_i);
      if (do_chk) chk("cap_strobe", 32'(data_rd_o), 32'd1);
      @(posedge clk_i);
      #1;
      mon_clr_i = 1'b0;
      if (clr) mq.delete();
      else mq.push_back(d);
      if (do_chk) begin
         chk("cap_valid",  32'(mon_valid_o),  32'd1);
         chk("cap_sample", 32'(mon_sample_o), 32'(d));
      end
   endtask

   initial begin
      vec_t vt[11];
      int   pulses;
      logic exp_rd;
      logic [15:0] d2;

      for (int i = 0; i < 64; i++) begin
         real r;
         r = 29491.2 * $sin(2.0 * 3.14159265358979 * i / 64.0);
         sine_tab[i] = 16'(32768 + $rtoi($floor(r + 0.5)));
      end

      vt[0]  = '{16'h1234, 1'b1, 16'hFFFF, 16'h0000, 8'd0, 16'd0};
      vt[1]  = '{16'h5555, 1'b0, 16'h5555, 16'h5555, 8'd0, 16'd0};
      vt[2]  = '{16'h9000, 1'b0, 16'h5555, 16'h9000, 8'd1, 16'd0};
      vt[3]  = '{16'h7000, 1'b0, 16'h5555, 16'h9000, 8'd1, 16'd0};
      vt[4]  = '{16'h7FFF, 1'b0, 16'h5555, 16'h9000, 8'd1, 16'd0};
      vt[5]  = '{16'h8000, 1'b0, 16'h5555, 16'h9000, 8'd2, 16'd3};
      vt[6]  = '{16'h0000, 1'b0, 16'h0000, 16'h9000, 8'd2, 16'd3};
      vt[7]  = '{16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 8'd3, 16'd2};
      vt[8]  = '{16'h8000, 1'b1, 16'hFFFF, 16'h0000, 8'd0, 16'd0};
      vt[9]  = '{16'h7FFF, 1'b0, 16'h7FFF, 16'h7FFF, 8'd0, 16'd0};
      vt[10] = '{16'h8000, 1'b0, 16'h7FFF, 16'h8000, 8'd1, 16'd0};

      rst_n_i   = 1'b0;
      data_i    = 16'h0;
      mon_en_i  = 1'b0;
      mon_div_i = '0;
      mon_clr_i = 1'b0;

      // Reset values
      #12;
      chk("rst_rd",     32'(data_rd_o),    32'd0);
      chk("rst_valid",  32'(mon_valid_o),  32'd0);
      chk("rst_sample", 32'(mon_sample_o), 32'd0);
      chk("rst_min",    32'(mon_min_o),    32'hFFFF);
      chk("rst_max",    32'(mon_max_o),    32'd0);
      chk("rst_cross",  32'(mon_cross_o),  32'd0);
      chk("rst_period", 32'(mon_period_o), 32'd0);
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;

      // Test 1: build some state, then reset mid-cycle with en=1, div=0
      mon_en_i = 1'b1;
      cap(16'h7000, 1'b0, 1'b1);
      cap(16'h9000, 1'b0, 1'b1);
      chk("t1_cross_pre", 32'(mon_cross_o), 32'd1);
      #3;
      rst_n_i = 1'b0;
      #1;
      chk("t1_rd",     32'(data_rd_o),    32'd0);
      chk("t1_sample", 32'(mon_sample_o), 32'd0);
      chk("t1_min",    32'(mon_min_o),    32'hFFFF);
      chk("t1_max",    32'(mon_max_o),    32'd0);
      chk("t1_cross",  32'(mon_cross_o),  32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         chk("t1_rd_held", 32'(data_rd_o), 32'd0);
         @(posedge clk_i); #1;
         chk("t1_valid_held", 32'(mon_valid_o), 32'd0);
      end
      rst_n_i = 1'b1;
      mq.delete();
      cap(16'h4321, 1'b0, 1'b1);
      chk_model("t1_post");

      // Test 2: div=3, one strobe in four, div change at next reload
      mon_en_i = 1'b0;
      @(posedge clk_i); #1;
      mon_en_i  = 1'b1;
      mon_div_i = 8'd3;
      pulses = 0;
      for (int k = 0; k < 46; k++) begin
         if (k == 38) mon_div_i = 8'd0;
         d2 = 16'($urandom);
         data_i = d2;
         exp_rd = (k <= 40) ? (k % 4 == 0) : 1'b1;
         @(negedge clk_i);
         if (k < 40 && data_rd_o) pulses++;
         chk("t2_rd", 32'(data_rd_o), 32'(exp_rd));
         @(posedge clk_i); #1;
         chk("t2_valid", 32'(mon_valid_o), 32'(exp_rd));
         if (exp_rd) chk("t2_sample", 32'(mon_sample_o), 32'(d2));
      end
      chk("t2_pulses", 32'(pulses), 32'd10);

      // Test 6 and assorted rules: table of single captures
      cap(16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 11; i++) begin
         cap(vt[i].d, vt[i].clr, 1'b1);
         chk("tab_min",    32'(mon_min_o),    32'(vt[i].e_min));
         chk("tab_max",    32'(mon_max_o),    32'(vt[i].e_max));
         chk("tab_cross",  32'(mon_cross_o),  32'(vt[i].e_cross));
         chk("tab_period", 32'(mon_period_o), 32'(vt[i].e_per));
      end

      // Test 3: 90% sine, 130 captures
      cap(16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 130; i++) cap(sine_tab[i % 64], 1'b0, 1'b0);
      chk("t3_min",    32'(mon_min_o),    32'h0CCD);
      chk("t3_max",    32'(mon_max_o),    32'hF333);
      chk("t3_cross",  32'(mon_cross_o),  32'd2);
      chk("t3_period", 32'(mon_period_o), 32'd64);
      chk_model("t3");

      // Test 4: alternating source, crossing count saturation
      cap(16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 601; i++) cap((i % 2 == 0) ? 16'h7000 : 16'h9000, 1'b0, 1'b0);
      chk("t4_cross",  32'(mon_cross_o),  32'd255);
      chk("t4_period", 32'(mon_period_o), 32'd2);
      chk_model("t4");

      // Randomized captures against the reference model
      cap(16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) d2 = 16'($urandom);
         else d2 = 16'(16'h7FF0 + $urandom_range(0, 31));
         cap(d2, ($urandom_range(0, 39) == 0), 1'b1);
         chk_model("rnd");
      end

      // Test 5: long run below mid-scale, period saturation
      cap(16'h0, 1'b1, 1'b0);
      cap(16'h7000, 1'b0, 1'b0);
      cap(16'h9000, 1'b0, 1'b0);
      chk("t5_cross_pre", 32'(mon_cross_o), 32'd1);
      for (int i = 0; i < 70000; i++) cap(16'h7FFF, 1'b0, 1'b0);
      cap(16'h8000, 1'b0, 1'b1);
      chk("t5_cross",  32'(mon_cross_o),  32'd2);
      chk("t5_period", 32'(mon_period_o), 32'hFFFF);
      chk_model("t5");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
